gpio_in_filter: RTL
===================

GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 22, number of filtered input bits (1..32).
REQ-002 SHALL have parameter PRESC_DEFAULT, default 16'd999, reset value of the sample-tick prescaler.
REQ-003 SHALL have parameter DB_DEFAULT, default 8'd4, reset value of the debounce tick count.
REQ-004 SHALL have port OPB_CLK  input  1  single clock, rising edge, for all logic.
REQ-005 SHALL have port OPB_RST  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port OPB_DI  input  32  OPB write data.
REQ-007 SHALL have port OPB_DO  output  32  OPB read data, registered.
REQ-008 SHALL have port OPB_ADDR  input  32  OPB address; only [3:0] is decoded.
REQ-009 SHALL have port FILT_RE  input  1  read enable for this block.
REQ-010 SHALL have port FILT_WE  input  1  write enable for this block.
REQ-011 SHALL have port RAW_IN  input  WIDTH  asynchronous board inputs (limit switches, interlock loop states).
REQ-012 SHALL have port FILT_OUT  output  WIDTH  debounced levels; these drive the GPIO input-register bits.
REQ-013 SHALL have port CHG_IRQ  output  1  level interrupt, high while any enabled change flag is set.

Function
REQ-014 SHALL pass each RAW_IN bit through a 2-flop synchronizer; SYNC is the second-stage value.
REQ-015 SHALL run a 16-bit prescaler counting 0..PRESC; TICK is a one-cycle pulse when count==PRESC, and the count then wraps to 0.
REQ-016 SHALL restart the prescaler at 0 on any write to PRESC; PRESC=0 gives TICK every cycle.
REQ-017 SHALL keep one 8-bit counter per bit; on TICK, if SYNC!=FILT_OUT the counter increments, else it clears to 0.
REQ-018 SHALL, when an incremented counter reaches DB_CNT, load FILT_OUT with SYNC and clear the counter in the same cycle.
REQ-019 SHALL, when DB_CNT=0, bypass the filter: FILT_OUT follows SYNC every cycle and the counters are held at 0.
REQ-020 SHALL clear all debounce counters on a write to DB_CNT; FILT_OUT is unchanged by the write.
REQ-021 SHALL set CHG[i] in the cycle after FILT_OUT[i] changes value, for either edge.
REQ-022 SHALL clear CHG bits written with 1 at address 0x1 (write-1-to-clear); if set and clear hit the same bit in the same cycle, set wins.
REQ-023 SHALL register CHG_IRQ = OR(CHG & IRQ_EN), so it asserts 1 cycle after the enabling condition.
REQ-024 SHALL decode OPB_ADDR[3:0]: 0x0 FILT (RO), 0x1 CHG (W1C), 0x2 IRQ_EN (RW), 0x3 PRESC (RW, [15:0]), 0x4 DB_CNT (RW, [7:0]).
REQ-025 SHALL return read data on OPB_DO 1 cycle after FILT_RE, zero-extended above the field width.
REQ-026 SHALL drive OPB_DO=0 when FILT_RE is low or the address is unmapped; writes to RO or unmapped addresses have no effect.
REQ-027 SHALL ignore bits above WIDTH (or above the field width) on writes; reads of those bits return 0.
REQ-028 SHALL give writes priority over internal updates of the same register in the same cycle, except as stated in REQ-022.

Reset
REQ-029 SHALL, while OPB_RST is high, asynchronously force: sync flops, counters, FILT_OUT, CHG, IRQ_EN, CHG_IRQ and OPB_DO to 0; PRESC to PRESC_DEFAULT; DB_CNT to DB_DEFAULT.
REQ-030 SHALL, when reset asserts mid-debounce, discard the partial count; after release, filtering restarts from FILT_OUT=0.
REQ-031 SHALL, after reset release, produce the first TICK PRESC_DEFAULT+1 cycles later.

Verification
REQ-032 Scenario: PRESC=3, DB_CNT=4, RAW_IN[0] steps 0->1 and holds -> FILT_OUT[0]=1 after the 4th TICK (at most 2+16 cycles), CHG[0]=1, CHG_IRQ stays 0 while IRQ_EN=0.
REQ-033 Scenario: PRESC=3, DB_CNT=4, RAW_IN[0] pulses high for 3 TICKs then low -> FILT_OUT[0] stays 0 and CHG=0.
REQ-034 Scenario: IRQ_EN=0x1, CHG[0] set -> CHG_IRQ=1; write 0x1 to addr 0x1 -> CHG[0]=0 and CHG_IRQ=0 one cycle later; a set coincident with the clear leaves CHG[0]=1.
REQ-035 Scenario: DB_CNT=0, RAW_IN toggles every cycle -> FILT_OUT tracks it with 2-cycle latency.
REQ-036 Scenario: read addresses 0x3, 0x4, 0x7 after reset -> OPB_DO = PRESC_DEFAULT, DB_DEFAULT, then 0, each 1 cycle after FILT_RE; FILT_RE low -> OPB_DO=0.
REQ-037 Scenario: assert OPB_RST with a counter at 3 of 4 -> all outputs 0 immediately; after release, RAW_IN held high yields FILT_OUT=1 only after a full 4 TICKs.

Source files
------------

// File: rtl/gpio_in_filter_if.sv
// OPB-style register bus between the host and the GPIO input filter.
interface gpio_in_filter_if;
   logic [31:0] OPB_DI;
   logic [31:0] OPB_DO;
   logic [31:0] OPB_ADDR;
   logic        FILT_RE;
   logic        FILT_WE;

   modport master (output OPB_DI, OPB_ADDR, FILT_RE, FILT_WE, input OPB_DO);
   modport slave  (input OPB_DI, OPB_ADDR, FILT_RE, FILT_WE, output OPB_DO);
endinterface

// File: rtl/gpio_in_filter.sv
// Synchronizes and debounces board inputs, flags level changes and raises an
// enable-masked change interrupt; configured through a small register window.
module gpio_in_filter #(
   parameter int          WIDTH         = 22,
   parameter logic [15:0] PRESC_DEFAULT = 16'd999,
   parameter logic [7:0]  DB_DEFAULT    = 8'd4
) (
   input  logic             OPB_CLK,
   input  logic             OPB_RST,
   gpio_in_filter_if.slave  bus,
   input  logic [WIDTH-1:0] RAW_IN,
   output logic [WIDTH-1:0] FILT_OUT,
   output logic             CHG_IRQ
);

   logic [WIDTH-1:0] sync1, sync2, filt_q, filt_d, chg, irq_en;
   logic [15:0]      presc, pcnt;
   logic [7:0]       db_cnt;
   logic             tick, bypass;
   logic             wr_chg, wr_irq, wr_presc, wr_db;
   logic [WIDTH-1:0] di_w, clr_mask;
   logic [31:0]      rdata;
   logic             unused_bits;

   assign unused_bits = ^{bus.OPB_ADDR, bus.OPB_DI};

   assign di_w     = bus.OPB_DI[WIDTH-1:0];
   assign wr_chg   = bus.FILT_WE && (bus.OPB_ADDR[3:0] == 4'h1);
   assign wr_irq   = bus.FILT_WE && (bus.OPB_ADDR[3:0] == 4'h2);
   assign wr_presc = bus.FILT_WE && (bus.OPB_ADDR[3:0] == 4'h3);
   assign wr_db    = bus.FILT_WE && (bus.OPB_ADDR[3:0] == 4'h4);

   assign tick     = (pcnt == presc);
   assign bypass   = (db_cnt == 8'd0);
   // In bypass the output is the synchronizer itself; filt_q shadows it so
   // leaving bypass does not glitch the level.
   assign FILT_OUT = bypass ? sync2 : filt_q;
   assign clr_mask = wr_chg ? di_w : '0;

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         sync1  <= '0;
         sync2  <= '0;
         filt_d <= '0;
      end else begin
         sync1  <= RAW_IN;
         sync2  <= sync1;
         filt_d <= FILT_OUT;
      end
   end

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST)                pcnt <= '0;
      else if (wr_presc || tick)  pcnt <= '0;
      else                        pcnt <= pcnt + 16'd1;
   end

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         presc   <= PRESC_DEFAULT;
         db_cnt  <= DB_DEFAULT;
         irq_en  <= '0;
         chg     <= '0;
         CHG_IRQ <= 1'b0;
      end else begin
         if (wr_presc) presc  <= bus.OPB_DI[15:0];
         if (wr_db)    db_cnt <= bus.OPB_DI[7:0];
         if (wr_irq)   irq_en <= di_w;
         // a new change event beats a coincident W1C on the same bit
         chg     <= (chg & ~clr_mask) | (FILT_OUT ^ filt_d);
         CHG_IRQ <= |(chg & irq_en);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [7:0] cnt, cnt_inc;
      logic       lvl;
      assign cnt_inc   = cnt + 8'd1;
      assign filt_q[i] = lvl;

      always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
         if (OPB_RST) begin
            cnt <= '0;
            lvl <= 1'b0;
         end else if (bypass) begin
            cnt <= '0;
            lvl <= sync2[i];
         end else if (wr_db) begin
            cnt <= '0;
         end else if (tick) begin
            if (sync2[i] != lvl) begin
               if (cnt_inc == db_cnt) begin
                  lvl <= sync2[i];
                  cnt <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end else begin
               cnt <= '0;
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (bus.OPB_ADDR[3:0])
         4'h0:    rdata[WIDTH-1:0] = FILT_OUT;
         4'h1:    rdata[WIDTH-1:0] = chg;
         4'h2:    rdata[WIDTH-1:0] = irq_en;
         4'h3:    rdata[15:0]      = presc;
         4'h4:    rdata[7:0]       = db_cnt;
         default: rdata            = '0;
      endcase
   end

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST)  bus.OPB_DO <= '0;
      else          bus.OPB_DO <= bus.FILT_RE ? rdata : 32'd0;
   end

endmodule
